// File: rtl/tap_sdram_bridge_if.sv
// tap_sdram_bridge_if: toggle-handshake SDRAM port between the TAP bridge and the memory controller
interface tap_sdram_bridge_if #(parameter int AW = 24);
   logic          mem_req;
   logic          mem_ack;
   logic [AW-2:0] mem_a;
   logic [1:0]    mem_ds;
   logic          mem_we;
   logic [15:0]   mem_d;
   logic [15:0]   mem_q;
   modport master (output mem_req, mem_a, mem_ds, mem_we, mem_d, input mem_ack, mem_q);
   modport slave  (input mem_req, mem_a, mem_ds, mem_we, mem_d, output mem_ack, mem_q);
endinterface

// File: rtl/tap_sdram_bridge.sv
// tap_sdram_bridge: streams TAP downloads into SDRAM and serves player byte reads through a one-word cache
module tap_sdram_bridge #(
   parameter int AW = 24
) (
   input  logic               clk_sys,
   input  logic               reset_n,
   input  logic               dl_active,
   input  logic               dl_wr,
   input  logic [AW-1:0]      dl_addr,
   input  logic [7:0]         dl_data,
   input  logic               byte_req,
   input  logic [AW-1:0]      byte_addr,
   output logic               byte_ack,
   output logic [7:0]         byte_out,
   output logic               eof,
   output logic [AW-1:0]      tape_last,
   output logic               tape_valid,
   output logic               dl_overrun,
   tap_sdram_bridge_if.master mem
);
   typedef enum logic [2:0] {SYNC, IDLE, WR_WAIT, RD_WAIT, DELIVER} state_t;
   state_t state, nxt;
   logic dl_active_q, rd_abort, cache_valid, pend_valid;
   logic [AW-2:0] cache_tag;
   logic [15:0] cache_data;
   logic [AW-1:0] pend_addr, wr_addr;
   logic [7:0] pend_data, wr_data;
   logic dl_rise, mem_idle, rd_pend, oob, hit, discard, drop, accept, to_slot;
   logic wr_go, wr_pend, rd_eof, rd_hit, rd_miss, fill, deliver;
   assign dl_rise  = dl_active & ~dl_active_q;
   assign mem_idle = mem.mem_req == mem.mem_ack;
   assign rd_pend  = (byte_req != byte_ack) & ~dl_active;
   assign oob      = ~tape_valid | (byte_addr > tape_last);
   assign hit      = cache_valid & (cache_tag == byte_addr[AW-1:1]);
   // a read answered after a new download started, or racing a write to its word, is stale
   assign discard  = rd_abort | dl_active | (dl_wr & (dl_addr[AW-1:1] == mem.mem_a));
   assign drop     = dl_wr & pend_valid & ~wr_pend;
   assign accept   = dl_wr & ~drop;
   assign to_slot  = accept & ~(wr_go & ~wr_pend);
   assign wr_addr  = wr_pend ? pend_addr : dl_addr;
   assign wr_data  = wr_pend ? pend_data : dl_data;
   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) state <= SYNC;
      else state <= nxt;
   always_comb begin
      nxt = state;
      wr_go = 1'b0;
      wr_pend = 1'b0;
      rd_eof = 1'b0;
      rd_hit = 1'b0;
      rd_miss = 1'b0;
      fill = 1'b0;
      deliver = 1'b0;
      case (state)
         SYNC: nxt = IDLE;
         IDLE: begin
            if (pend_valid | dl_wr) begin
               wr_go = 1'b1;
               wr_pend = pend_valid;
               nxt = WR_WAIT;
            end else if (rd_pend) begin
               rd_eof = oob;
               rd_hit = ~oob & hit;
               rd_miss = ~oob & ~hit;
               nxt = (~oob & ~hit) ? RD_WAIT : IDLE;
            end
         end
         WR_WAIT: nxt = mem_idle ? IDLE : WR_WAIT;
         RD_WAIT: begin
            fill = mem_idle & ~discard;
            nxt = !mem_idle ? RD_WAIT : discard ? IDLE : DELIVER;
         end
         DELIVER: begin
            deliver = ~dl_active;
            nxt = IDLE;
         end
         default: nxt = SYNC;
      endcase
   end
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         dl_active_q <= 1'b0;
         rd_abort <= 1'b0;
         byte_ack <= 1'b0;
         byte_out <= 8'h00;
         eof <= 1'b0;
         tape_last <= '0;
         tape_valid <= 1'b0;
         dl_overrun <= 1'b0;
         mem.mem_req <= 1'b0;
         mem.mem_we <= 1'b0;
         mem.mem_a <= '0;
         mem.mem_ds <= 2'b11;
         mem.mem_d <= 16'h0000;
         cache_valid <= 1'b0;
         cache_tag <= '0;
         cache_data <= 16'h0000;
         pend_valid <= 1'b0;
         pend_addr <= '0;
         pend_data <= 8'h00;
      end else begin
         dl_active_q <= dl_active;
         if (state == SYNC) mem.mem_req <= mem.mem_ack;
         if (wr_go) begin
            mem.mem_req <= ~mem.mem_req;
            mem.mem_a <= wr_addr[AW-1:1];
            mem.mem_ds <= wr_addr[0] ? 2'b10 : 2'b01;
            mem.mem_we <= 1'b1;
            mem.mem_d <= {wr_data, wr_data};
         end
         if (rd_miss) begin
            mem.mem_req <= ~mem.mem_req;
            mem.mem_a <= byte_addr[AW-1:1];
            mem.mem_ds <= 2'b11;
            mem.mem_we <= 1'b0;
         end
         rd_abort <= rd_miss ? 1'b0 : rd_abort | dl_rise;
         if (rd_eof | rd_hit | deliver) begin
            byte_ack <= ~byte_ack;
            byte_out <= rd_eof ? 8'h00 : byte_addr[0] ? cache_data[15:8] : cache_data[7:0];
         end
         eof <= (rd_eof | rd_hit | deliver) ? rd_eof : eof & ~dl_rise;
         if (dl_rise) begin
            tape_last <= '0;
            tape_valid <= 1'b0;
            dl_overrun <= 1'b0;
         end
         if (accept) begin
            tape_last <= dl_addr;
            tape_valid <= 1'b1;
         end
         if (drop) dl_overrun <= 1'b1;
         pend_valid <= to_slot | (pend_valid & ~wr_pend);
         if (to_slot) begin
            pend_addr <= dl_addr;
            pend_data <= dl_data;
         end
         if (fill) begin
            cache_data <= mem.mem_q;
            cache_tag <= mem.mem_a;
         end
         cache_valid <= fill | (cache_valid & ~dl_rise & ~(accept & (dl_addr[AW-1:1] == cache_tag)));
      end
   end
endmodule

// File: tb/tb_tap_sdram_bridge.sv
// tb_tap_sdram_bridge: randomized bench with a tape-level reference model and a toggle-handshake SDRAM model
module tb_tap_sdram_bridge;
   localparam int AW = 24;
   typedef struct packed {logic [AW-2:0] a; logic [1:0] ds; logic [15:0] d;} wr_t;
   logic clk_sys = 1'b0, reset_n = 1'b0;
   logic dl_active = 1'b0, dl_wr = 1'b0, byte_req = 1'b0;
   logic [AW-1:0] dl_addr = '0, byte_addr = '0;
   logic [7:0] dl_data = 8'h00;
   logic byte_ack, eof, tape_valid, dl_overrun;
   logic [7:0] byte_out;
   logic [AW-1:0] tape_last;
   int n_chk = 0, n_pass = 0;
   tap_sdram_bridge_if #(.AW(AW)) mif();
   tap_sdram_bridge #(.AW(AW)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .dl_active(dl_active), .dl_wr(dl_wr),
      .dl_addr(dl_addr), .dl_data(dl_data), .byte_req(byte_req), .byte_addr(byte_addr),
      .byte_ack(byte_ack), .byte_out(byte_out), .eof(eof), .tape_last(tape_last),
      .tape_valid(tape_valid), .dl_overrun(dl_overrun), .mem(mif)
   );
   always #5 clk_sys = ~clk_sys;
   // SDRAM model: serves a request after it has been pending for lat+1 edges
   logic [7:0] sd [int];
   int lat = 2, lat_cnt = 0, rd_count = 0;
   bit hold = 1'b0;
   wr_t wq [$];
   function automatic logic [7:0] sd_rd(int a);
      return sd.exists(a) ? sd[a] : 8'h00;
   endfunction
   always @(posedge clk_sys) begin
      if (reset_n && mif.mem_req != mif.mem_ack && !hold) begin
         if (lat_cnt < lat) lat_cnt++;
         else begin
            lat_cnt = 0;
            if (mif.mem_we) begin
               wq.push_back({mif.mem_a, mif.mem_ds, mif.mem_d});
               if (mif.mem_ds[0]) sd[2*int'(mif.mem_a)] = mif.mem_d[7:0];
               if (mif.mem_ds[1]) sd[2*int'(mif.mem_a)+1] = mif.mem_d[15:8];
            end else begin
               rd_count++;
               mif.mem_q <= {sd_rd(2*int'(mif.mem_a)+1), sd_rd(2*int'(mif.mem_a))};
            end
            mif.mem_ack <= mif.mem_req;
         end
      end else lat_cnt = 0;
   end
   // tape-level reference: bytes downloaded, last address, last fetched word
   logic [7:0] ref_mem [int];
   logic [AW-1:0] ref_last = '0;
   bit ref_valid = 1'b0, c_ok = 1'b0;
   logic [AW-2:0] c_word = '0;
   function automatic bit in_range(logic [AW-1:0] a);
      return ref_valid && a <= ref_last;
   endfunction
   function automatic logic [7:0] exp_byte(logic [AW-1:0] a);
      return in_range(a) ? ref_mem[int'(a)] : 8'h00;
   endfunction
   function automatic bit exp_fetch(logic [AW-1:0] a);
      bit f = in_range(a) && !(c_ok && c_word == a[AW-1:1]);
      if (in_range(a)) begin
         c_word = a[AW-1:1];
         c_ok = 1'b1;
      end
      return f;
   endfunction
   function automatic wr_t exp_wr(logic [AW-1:0] a, logic [7:0] d);
      return {a[AW-1:1], a[0] ? 2'b10 : 2'b01, d, d};
   endfunction
   task automatic tick(int n = 1);
      repeat (n) @(negedge clk_sys);
   endtask
   task automatic dl_start;
      dl_active = 1'b0;
      tick();
      dl_active = 1'b1;
      ref_valid = 1'b0;
      ref_last = '0;
      c_ok = 1'b0;
      tick(2);
   endtask
   task automatic dl_end;
      dl_active = 1'b0;
      tick(2);
   endtask
   task automatic dl_byte(input logic [AW-1:0] a, input logic [7:0] d);
      dl_wr = 1'b1;
      dl_addr = a;
      dl_data = d;
      tick();
      dl_wr = 1'b0;
      ref_mem[int'(a)] = d;
      ref_last = a;
      ref_valid = 1'b1;
      if (c_ok && c_word == a[AW-1:1]) c_ok = 1'b0;
      tick(8);
   endtask
   task automatic do_read(input logic [AW-1:0] a, output logic [7:0] b, output logic e, output int cyc);
      byte_addr = a;
      byte_req = ~byte_req;
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (byte_ack !== byte_req && cyc < 200);
      b = (byte_ack === byte_req) ? byte_out : 8'hxx;
      e = (byte_ack === byte_req) ? eof : 1'bx;
   endtask
   task automatic test_reset;
      mif.mem_ack <= 1'b1;
      mif.mem_q <= 16'h0000;
      tick(3);
      n_chk++; if ({byte_ack, byte_out, eof, tape_last, tape_valid, dl_overrun} !== '0) $display("FAIL reset_player got %h want 0", {byte_ack, byte_out, eof, tape_last, tape_valid, dl_overrun}); else n_pass++;
      n_chk++; if ({mif.mem_req, mif.mem_we, mif.mem_a, mif.mem_ds, mif.mem_d} !== {1'b0, 1'b0, 23'h0, 2'b11, 16'h0}) $display("FAIL reset_mem got req=%b we=%b a=%h ds=%b d=%h want 0 0 0 11 0", mif.mem_req, mif.mem_we, mif.mem_a, mif.mem_ds, mif.mem_d); else n_pass++;
      reset_n = 1'b1;
      tick(5);
      n_chk++; if (mif.mem_req !== 1'b1) $display("FAIL sync_req got %b want 1", mif.mem_req); else n_pass++;
      n_chk++; if (wq.size() + rd_count != 0) $display("FAIL sync_no_txn got %0d want 0", wq.size() + rd_count); else n_pass++;
      n_chk++; if ({byte_ack, eof, tape_valid, dl_overrun} !== 4'b0000) $display("FAIL sync_outputs got %b want 0000", {byte_ack, eof, tape_valid, dl_overrun}); else n_pass++;
   endtask
   task automatic test_download;
      logic [7:0] dv [3] = '{8'h11, 8'h22, 8'h33};
      wr_t got;
      wq.delete();
      dl_start();
      for (int i = 0; i < 3; i++) dl_byte(AW'(i), dv[i]);
      dl_end();
      n_chk++; if (wq.size() != 3) $display("FAIL dl_count got %0d want 3", wq.size()); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         got = (i < wq.size()) ? wq[i] : 'x;
         n_chk++; if (got !== exp_wr(AW'(i), dv[i])) $display("FAIL dl_write%0d got %h want %h", i, got, exp_wr(AW'(i), dv[i])); else n_pass++;
      end
      n_chk++; if ({tape_last, tape_valid} !== {24'd2, 1'b1}) $display("FAIL dl_tape got last=%h valid=%b want 2 1", tape_last, tape_valid); else n_pass++;
   endtask
   task automatic test_read_cache;
      logic [7:0] b;
      logic e;
      int cyc, rc;
      rc = rd_count;
      void'(exp_fetch(AW'(0)));
      do_read(AW'(0), b, e, cyc);
      n_chk++; if ({b, e} !== {8'h11, 1'b0}) $display("FAIL rd0 got %h/%b want 11/0", b, e); else n_pass++;
      n_chk++; if (rd_count - rc != 1) $display("FAIL rd0_fetch got %0d want 1", rd_count - rc); else n_pass++;
      rc = rd_count;
      void'(exp_fetch(AW'(1)));
      do_read(AW'(1), b, e, cyc);
      n_chk++; if ({b, e} !== {8'h22, 1'b0}) $display("FAIL rd1_hit got %h/%b want 22/0", b, e); else n_pass++;
      n_chk++; if (cyc != 1 || rd_count != rc) $display("FAIL rd1_hit_latency got cyc=%0d fetch=%0d want 1/0", cyc, rd_count - rc); else n_pass++;
   endtask
   task automatic test_eof;
      logic [7:0] b;
      logic e, req0;
      int cyc;
      req0 = mif.mem_req;
      do_read(AW'(3), b, e, cyc);
      n_chk++; if ({b, e} !== {8'h00, 1'b1}) $display("FAIL eof_rd got %h/%b want 00/1", b, e); else n_pass++;
      n_chk++; if (mif.mem_req !== req0 || cyc != 1) $display("FAIL eof_no_mem got req=%b cyc=%0d want %b/1", mif.mem_req, cyc, req0); else n_pass++;
   endtask
   task automatic test_overrun;
      wq.delete();
      dl_start();
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         dl_wr = 1'b1;
         dl_addr = AW'(i);
         dl_data = 8'hA0 + 8'(i);
         tick();
         dl_wr = 1'b0;
         tick();
      end
      tick(10);
      hold = 1'b0;
      tick(20);
      ref_mem[0] = 8'hA0;
      ref_mem[1] = 8'hA1;
      ref_last = AW'(1);
      ref_valid = 1'b1;
      n_chk++; if (dl_overrun !== 1'b1) $display("FAIL ovr_flag got %b want 1", dl_overrun); else n_pass++;
      n_chk++; if (wq.size() != 2) $display("FAIL ovr_count got %0d want 2", wq.size()); else n_pass++;
      n_chk++; if (wq.size() == 2 && (wq[0] !== exp_wr(AW'(0), 8'hA0) || wq[1] !== exp_wr(AW'(1), 8'hA1))) $display("FAIL ovr_writes got %h %h want %h %h", wq[0], wq[1], exp_wr(AW'(0), 8'hA0), exp_wr(AW'(1), 8'hA1)); else n_pass++;
      n_chk++; if (tape_last !== ref_last) $display("FAIL ovr_last got %h want %h", tape_last, ref_last); else n_pass++;
      dl_start();
      n_chk++; if ({dl_overrun, tape_valid} !== 2'b00) $display("FAIL ovr_clear got %b want 00", {dl_overrun, tape_valid}); else n_pass++;
      dl_end();
   endtask
   task automatic test_invalidate;
      logic [7:0] b;
      logic e;
      int cyc, rc;
      bit f;
      dl_start();
      for (int i = 0; i < 4; i++) dl_byte(AW'(i), 8'h11 * 8'(i + 1));
      dl_end();
      void'(exp_fetch(AW'(0)));
      do_read(AW'(0), b, e, cyc);
      dl_byte(AW'(1), 8'h5A);
      rc = rd_count;
      f = exp_fetch(AW'(0));
      do_read(AW'(0), b, e, cyc);
      n_chk++; if (rd_count - rc != int'(f)) $display("FAIL inv_refetch got %0d want %0d", rd_count - rc, f); else n_pass++;
      n_chk++; if (b !== exp_byte(AW'(0))) $display("FAIL inv_rd0 got %h want %h", b, exp_byte(AW'(0))); else n_pass++;
      rc = rd_count;
      f = exp_fetch(AW'(1));
      do_read(AW'(1), b, e, cyc);
      n_chk++; if ({b, rd_count - rc} !== {exp_byte(AW'(1)), int'(f)}) $display("FAIL inv_rd1 got %h/%0d want %h/%0d", b, rd_count - rc, exp_byte(AW'(1)), f); else n_pass++;
   endtask
   task automatic test_discard;
      int cyc;
      dl_start();
      dl_byte(AW'(0), 8'hC3);
      dl_byte(AW'(1), 8'h3C);
      dl_end();
      hold = 1'b1;
      byte_addr = AW'(1);
      byte_req = ~byte_req;
      tick(3);
      dl_active = 1'b1;
      ref_valid = 1'b0;
      c_ok = 1'b0;
      tick(2);
      hold = 1'b0;
      tick(12);
      n_chk++; if (byte_ack === byte_req) $display("FAIL discard_noack got ack=%b want %b", byte_ack, ~byte_req); else n_pass++;
      dl_byte(AW'(0), 8'h96);
      dl_byte(AW'(1), 8'h69);
      dl_active = 1'b0;
      cyc = 0;
      while (byte_ack !== byte_req && cyc < 100) begin
         tick();
         cyc++;
      end
      void'(exp_fetch(AW'(1)));
      n_chk++; if ({byte_ack === byte_req, byte_out, eof} !== {1'b1, exp_byte(AW'(1)), 1'b0}) $display("FAIL discard_after got ack_ok=%b %h/%b want 1 %h/0", byte_ack === byte_req, byte_out, eof, exp_byte(AW'(1))); else n_pass++;
   endtask
   task automatic test_random;
      int n, cyc, rc;
      logic [AW-1:0] a;
      logic [7:0] b, eb;
      logic e;
      bit f;
      wr_t got;
      n = $urandom_range(20, 40);
      wq.delete();
      dl_start();
      for (int i = 0; i < n; i++) dl_byte(AW'(i), 8'($urandom));
      dl_end();
      n_chk++; if (wq.size() != n) $display("FAIL rnd_dl_count got %0d want %0d", wq.size(), n); else n_pass++;
      for (int i = 0; i < n; i++) begin
         got = (i < wq.size()) ? wq[i] : 'x;
         n_chk++; if (got !== exp_wr(AW'(i), ref_mem[i])) $display("FAIL rnd_dl%0d got %h want %h", i, got, exp_wr(AW'(i), ref_mem[i])); else n_pass++;
      end
      for (int k = 0; k < 40; k++) begin
         a = AW'($urandom_range(0, n + 3));
         lat = $urandom_range(2, 5);
         rc = rd_count;
         eb = exp_byte(a);
         f = exp_fetch(a);
         do_read(a, b, e, cyc);
         n_chk++; if ({b, e} !== {eb, !in_range(a)}) $display("FAIL rnd_rd%0d a=%h got %h/%b want %h/%b", k, a, b, e, eb, !in_range(a)); else n_pass++;
         n_chk++; if (rd_count - rc != int'(f)) $display("FAIL rnd_fetch%0d a=%h got %0d want %0d", k, a, rd_count - rc, f); else n_pass++;
      end
      lat = 2;
   endtask
   initial begin
      test_reset();
      test_download();
      test_read_cache();
      test_eof();
      test_overrun();
      test_invalidate();
      test_discard();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
